// File: rtl/thor2023_load_align.sv
`default_nettype none
// ============================================================================
// Module   : thor2023_load_align
// Purpose  : Aligns raw BIU load beats, merges line-crossing beats, and
//            masks/extends the result for register-file writeback.
// Revision : 1.0
// ============================================================================
module thor2023_load_align #(
    parameter int DBW = 128,
    parameter int RW  = 96,
    parameter int TW  = 6
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           flush_i,
    input  logic           in_v,
    output logic           in_rdy,
    input  logic [TW-1:0]  in_tgt,
    input  logic [3:0]     in_adr,
    input  logic [2:0]     in_sz,
    input  logic           in_sext,
    input  logic [DBW-1:0] in_dat,
    output logic           wb_v,
    input  logic           wb_rdy,
    output logic [TW-1:0]  wb_tgt,
    output logic [RW-1:0]  wb_dat,
    output logic           wb_err
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic [DBW-1:0] r_hold;
    logic [TW-1:0]  r_tgt;
    logic [3:0]     r_adr;
    logic [2:0]     r_sz;
    logic           r_sext;
    logic           r_wb_v;
    logic [TW-1:0]  r_wb_tgt;
    logic [RW-1:0]  r_wb_dat;
    logic           r_wb_err;

    logic           w_out_free;
    logic           w_acc;
    logic           w_split;
    logic           w_load;
    logic           w_latch;
    logic [4:0]     w_nbytes;
    logic [4:0]     w_n1;
    logic [DBW-1:0] w_shift;
    logic [DBW-1:0] w_merge;
    logic [DBW-1:0] w_aligned;
    logic [2:0]     w_sz_eff;
    logic           w_sext_eff;
    logic [RW-1:0]  w_ext;
    logic           w_unused;

    assign w_out_free = !r_wb_v || wb_rdy;
    assign in_rdy     = w_out_free && !rst_i;
    assign w_acc      = in_v && in_rdy && !flush_i;

    always_comb begin
        w_nbytes = 5'd12;
        case (in_sz)
            3'd0:    w_nbytes = 5'd1;
            3'd1:    w_nbytes = 5'd2;
            3'd2:    w_nbytes = 5'd3;
            3'd3:    w_nbytes = 5'd4;
            3'd4:    w_nbytes = 5'd5;
            3'd5:    w_nbytes = 5'd8;
            default: w_nbytes = 5'd12;
        endcase
    end

    assign w_split = ({1'b0, in_adr} + w_nbytes) > 5'd16;
    assign w_load  = w_acc && ((r_state == c_st_hold) || !w_split);
    assign w_latch = w_acc && (r_state == c_st_idle) && w_split;

    // Second beat lands right above the n1 bytes kept from the first beat;
    // the result never exceeds 12 bytes, so a 128-bit window suffices.
    assign w_n1      = 5'd16 - {1'b0, r_adr};
    assign w_shift   = in_dat >> {in_adr, 3'b000};
    assign w_merge   = r_hold | (in_dat << {w_n1, 3'b000});
    assign w_aligned = (r_state == c_st_hold) ? w_merge : w_shift;
    assign w_unused  = ^w_aligned[DBW-1:RW];

    assign w_sz_eff   = (r_state == c_st_hold) ? r_sz   : in_sz;
    assign w_sext_eff = (r_state == c_st_hold) ? r_sext : in_sext;

    always_comb begin
        w_ext = w_aligned[RW-1:0];
        case (w_sz_eff)
            3'd0: w_ext = {{(RW-8){w_sext_eff & w_aligned[7]}},   w_aligned[7:0]};
            3'd1: w_ext = {{(RW-16){w_sext_eff & w_aligned[15]}}, w_aligned[15:0]};
            3'd2: w_ext = {{(RW-24){w_sext_eff & w_aligned[23]}}, w_aligned[23:0]};
            3'd3: w_ext = {{(RW-32){w_sext_eff & w_aligned[31]}}, w_aligned[31:0]};
            3'd4: w_ext = {{(RW-40){w_sext_eff & w_aligned[39]}}, w_aligned[39:0]};
            3'd5: w_ext = {{(RW-64){w_sext_eff & w_aligned[63]}}, w_aligned[63:0]};
            default: w_ext = w_aligned[RW-1:0];
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = c_st_idle;
        end else if (w_acc) begin
            if (r_state == c_st_hold) begin
                w_state_nxt = c_st_idle;
            end else if (w_split) begin
                w_state_nxt = c_st_hold;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
            r_hold  <= '0;
            r_tgt   <= '0;
            r_adr   <= '0;
            r_sz    <= '0;
            r_sext  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (flush_i) begin
                r_hold <= '0;
            end else if (w_latch) begin
                r_hold <= w_shift;
                r_tgt  <= in_tgt;
                r_adr  <= in_adr;
                r_sz   <= in_sz;
                r_sext <= in_sext;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wb_v   <= 1'b0;
            r_wb_tgt <= '0;
            r_wb_dat <= '0;
            r_wb_err <= 1'b0;
        end else if (flush_i) begin
            r_wb_v <= 1'b0;
        end else if (w_load) begin
            r_wb_v   <= 1'b1;
            r_wb_tgt <= (r_state == c_st_hold) ? r_tgt : in_tgt;
            r_wb_dat <= w_ext;
            r_wb_err <= (w_sz_eff == 3'd7);
        end else if (r_wb_v && wb_rdy) begin
            r_wb_v <= 1'b0;
        end
    end

    assign wb_v   = r_wb_v;
    assign wb_tgt = r_wb_tgt;
    assign wb_dat = r_wb_dat;
    assign wb_err = r_wb_err;

endmodule
`default_nettype wire

// File: tb/tb_thor2023_load_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_thor2023_load_align
// Purpose  : Directed stimulus with a queue-based scoreboard for the
//            load-alignment stage.
// Revision : 1.0
// ============================================================================
module tb_thor2023_load_align;

    logic         clk_i = 1'b0;
    logic         rst_i, flush_i, in_v, in_rdy, in_sext;
    logic [5:0]   in_tgt;
    logic [3:0]   in_adr;
    logic [2:0]   in_sz;
    logic [127:0] in_dat;
    logic         wb_v, wb_rdy, wb_err;
    logic [5:0]   wb_tgt;
    logic [95:0]  wb_dat;

    typedef logic [102:0] exp_t; // {err, tgt, dat}
    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    thor2023_load_align #(.DBW(128), .RW(96), .TW(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_v(in_v), .in_rdy(in_rdy), .in_tgt(in_tgt), .in_adr(in_adr),
        .in_sz(in_sz), .in_sext(in_sext), .in_dat(in_dat),
        .wb_v(wb_v), .wb_rdy(wb_rdy), .wb_tgt(wb_tgt), .wb_dat(wb_dat),
        .wb_err(wb_err)
    );

    always #5 clk_i = ~clk_i;

    // Monitor: every consumed writeback must match the oldest expectation.
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (!rst_i && wb_v && wb_rdy) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got err=%b tgt=%0d dat=%h, required no output",
                         wb_err, wb_tgt, wb_dat);
            end else begin
                e = q.pop_front();
                if ({wb_err, wb_tgt, wb_dat} !== e) begin
                    n_fail++;
                    $display("FAIL wb_result: got err=%b tgt=%0d dat=%h, required err=%b tgt=%0d dat=%h",
                             wb_err, wb_tgt, wb_dat, e[102], e[101:96], e[95:0]);
                end
            end
        end
    end

    task automatic chk1(input string name, input logic [95:0] act, input logic [95:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [5:0] t, input logic [95:0] d, input logic e);
        q.push_back({e, t, d});
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Presents one beat and returns 1 time unit after the accepting edge.
    task automatic send(input logic [5:0] t, input logic [3:0] a, input logic [2:0] s,
                        input logic x, input logic [127:0] d);
        int k;
        in_v = 1'b1; in_tgt = t; in_adr = a; in_sz = s; in_sext = x; in_dat = d;
        k = 0;
        @(negedge clk_i);
        while (!in_rdy && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        chk1("send_in_rdy", {95'd0, in_rdy}, 96'd1);
        @(posedge clk_i);
        #1;
        in_v = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_v = 1'b0; in_tgt = '0; in_adr = '0;
        in_sz = '0; in_sext = 1'b0; in_dat = '0; wb_rdy = 1'b1;
        tick(2);
        @(negedge clk_i);
        chk1("rst_in_rdy", {95'd0, in_rdy}, 96'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk1("rst_wb_v",   {95'd0, wb_v},   96'd0);
        chk1("rst_wb_dat", wb_dat,          96'd0);
        chk1("rst_wb_tgt", {90'd0, wb_tgt}, 96'd0);
        chk1("rst_wb_err", {95'd0, wb_err}, 96'd0);

        // Non-split tetra, sign- then zero-extended
        push(6'd5, 96'hFFFF_FFFF_FFFF_FFFF_8000_0001, 1'b0);
        send(6'd5, 4'd4, 3'd3, 1'b1, 128'hDEADBEEF_CAFEF00D_80000001_12345678);
        chk1("latency_wb_v", {95'd0, wb_v}, 96'd1);
        push(6'd6, 96'h0000_0000_0000_0000_8000_0001, 1'b0);
        send(6'd6, 4'd4, 3'd3, 1'b0, 128'hDEADBEEF_CAFEF00D_80000001_12345678);

        // Split octa; second-beat attributes must be ignored
        push(6'd9, 96'h0000_0000_6655_4433_2211_BBAA, 1'b0);
        send(6'd9, 4'd14, 3'd5, 1'b0, {16'hBBAA, 112'h0123_4567_89AB_CDEF_0011_2233_4455});
        chk1("split_no_wb_beat1", {95'd0, wb_v}, 96'd0);
        send(6'd3, 4'd0, 3'd0, 1'b1, {80'hFFEE_DDCC_BBAA_9988_7766, 48'h6655_4433_2211});

        // Split n96 (no extension) and split sign-extended wyde at adr 15
        push(6'd10, {32'hCCBBAA99, 64'h8877665544332211}, 1'b0);
        send(6'd10, 4'd8, 3'd6, 1'b1, {64'h8877665544332211, 64'h0F0F0F0F0F0F0F0F});
        send(6'd0, 4'd3, 3'd2, 1'b0, {96'hDEAD_BEEF_0000_1111_2222_3333, 32'hCCBBAA99});
        push(6'd11, {{80{1'b1}}, 16'h9234}, 1'b0);
        send(6'd11, 4'd15, 3'd1, 1'b1, {8'h34, 120'h0});
        send(6'd0, 4'd0, 3'd0, 1'b0, {120'h5A, 8'h92});

        // Char at adr 1 and penta ending exactly on byte 15 (not split)
        push(6'd12, {{72{1'b1}}, 24'hC43322}, 1'b0);
        send(6'd12, 4'd1, 3'd2, 1'b1, {96'h1, 32'hC4332211});
        push(6'd13, {{56{1'b1}}, 40'h80_1122_3344}, 1'b0);
        send(6'd13, 4'd11, 3'd4, 1'b1, {40'h80_1122_3344, 88'h77});
        chk1("penta_no_hold_wb_v", {95'd0, wb_v}, 96'd1);
        tick(2);

        // Backpressure: output held stable, then no bubble on release
        wb_rdy = 1'b0;
        push(6'd20, 96'h55, 1'b0);
        send(6'd20, 4'd0, 3'd0, 1'b0, {120'h0, 8'h55});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk1("bp_in_rdy", {95'd0, in_rdy}, 96'd0);
            chk1("bp_wb_v",   {95'd0, wb_v},   96'd1);
            chk1("bp_wb_dat", wb_dat,          96'h55);
            chk1("bp_wb_tgt", {90'd0, wb_tgt}, 96'd20);
        end
        @(posedge clk_i); #1;
        wb_rdy = 1'b1;
        push(6'd21, 96'hA5, 1'b0);
        send(6'd21, 4'd3, 3'd0, 1'b0, {96'h0, 8'hA5, 24'h0});
        chk1("bp_no_bubble_wb_v", {95'd0, wb_v}, 96'd1);
        chk1("bp_new_wb_dat",     wb_dat,        96'hA5);

        // Back-to-back full throughput
        push(6'd22, 96'h11, 1'b0); send(6'd22, 4'd0, 3'd0, 1'b0, {120'h0, 8'h11});
        push(6'd23, 96'h22, 1'b0); send(6'd23, 4'd1, 3'd0, 1'b0, {112'h0, 8'h22, 8'h0});
        push(6'd24, 96'h33, 1'b0); send(6'd24, 4'd2, 3'd0, 1'b0, {104'h0, 8'h33, 16'h0});
        tick(2);

        // Flush while holding a first beat
        send(6'd30, 4'd14, 3'd5, 1'b0, {16'hBBAA, 112'h0});
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        push(6'd31, 96'h7F, 1'b0);
        send(6'd31, 4'd0, 3'd0, 1'b0, {120'h0, 8'h7F});
        tick(2);

        // Flush drops a same-cycle beat
        in_v = 1'b1; in_tgt = 6'd32; in_adr = 4'd0; in_sz = 3'd3; in_sext = 1'b0;
        in_dat = 128'h1234;
        flush_i = 1'b1;
        tick(1);
        in_v = 1'b0; flush_i = 1'b0;
        tick(2);
        chk1("flush_drop_beat_wb_v", {95'd0, wb_v}, 96'd0);

        // Flush drops a pending output
        wb_rdy = 1'b0;
        send(6'd33, 4'd0, 3'd0, 1'b0, 128'h44);
        chk1("flush_pend_wb_v_pre", {95'd0, wb_v}, 96'd1);
        flush_i = 1'b1;
        tick(1);
        flush_i = 1'b0;
        chk1("flush_pend_wb_v", {95'd0, wb_v}, 96'd0);
        wb_rdy = 1'b1;

        // Illegal size code, then a legal load clears the error
        push(6'd40, 96'hCCCC_DDDD_1111_2222_3333_4444, 1'b1);
        send(6'd40, 4'd0, 3'd7, 1'b1, 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444);
        push(6'd41, 96'hBEEF, 1'b0);
        send(6'd41, 4'd2, 3'd1, 1'b0, {96'h0, 16'hBEEF, 16'h0});
        tick(2);

        // Reset with a pending output, then reset while holding a first beat
        wb_rdy = 1'b0;
        send(6'd50, 4'd0, 3'd3, 1'b0, 128'h9999_8888);
        chk1("rst_mid_wb_v_pre", {95'd0, wb_v}, 96'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk1("rst_mid_in_rdy", {95'd0, in_rdy}, 96'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk1("rst_mid_wb_v",   {95'd0, wb_v},   96'd0);
        chk1("rst_mid_wb_dat", wb_dat,          96'd0);
        chk1("rst_mid_wb_tgt", {90'd0, wb_tgt}, 96'd0);
        wb_rdy = 1'b1;
        send(6'd51, 4'd14, 3'd5, 1'b0, {16'hBBAA, 112'h0});
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        push(6'd52, 96'h1234_5678, 1'b0);
        send(6'd52, 4'd0, 3'd3, 1'b0, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h1234_5678});

        tick(5);
        chk1("scoreboard_empty", 96'(q.size()), 96'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/thor2023_load_align.md
Name: thor2023_load_align

Overview:
- Load-data alignment stage between the BIU response FIFO (fifoFromCtrl) and the core's register-file writeback.
- Takes raw 128-bit response beats plus load attributes, shifts them by the low address bits, and merges two beats when an access crosses a 16-byte boundary.
- Masks to the access size, then sign- or zero-extends to 96 bits.
- Presents one writeback (target register and data) per load through a valid/ready handshake.

Parameters:
- DBW, 128, response data bus width in bits; fixed at 128, with the byte lane index 4 bits.
- RW, 96, register/result width in bits.
- TW, 6, target register number width.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, synchronous, active-high
- flush_i  input  1  rollback/flush; drops any held beat and any pending output
- in_v  input  1  response beat valid
- in_rdy  output  1  stage can accept a beat this cycle
- in_tgt  input  TW  destination register (sampled on first beat only)
- in_adr  input  4  byte address bits [3:0] of the access
- in_sz  input  3  size code: 0=byt(1B), 1=wyde(2B), 2=char(3B), 3=tetra(4B), 4=penta(5B), 5=octa(8B), 6=n96(12B), 7=illegal
- in_sext  input  1  1=sign-extend, 0=zero-extend
- in_dat  input  DBW  response data beat
- wb_v  output  1  writeback valid
- wb_rdy  input  1  writeback consumer ready
- wb_tgt  output  TW  destination register
- wb_dat  output  RW  aligned, extended result
- wb_err  output  1  illegal size code; qualified by wb_v

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, wb_v=0, wb_tgt=0, wb_dat=0, wb_err=0, hold buffer cleared. Reset overrides flush_i and any handshake in the same cycle.
- Handshakes:
  - out_free = !wb_v || wb_rdy.
  - in_rdy = out_free && !rst_i, in all states. in_rdy has no combinational path from in_v or in_* data.
  - A beat is accepted when in_v && in_rdy; the output is consumed when wb_v && wb_rdy.
- Size and split:
  - nbytes comes from in_sz per the size table; code 7 behaves as 12 bytes and sets the error flag.
  - A split access is one where in_adr + nbytes > 16.
  - n1 = 16 - in_adr is the number of bytes taken from the first beat.
- States:
  - IDLE, accepting a non-split beat: aligned = in_dat >> (in_adr*8). Load the output register the same edge (1-cycle latency: wb_v=1 on the next cycle). Remain in IDLE.
  - IDLE, accepting a split beat: store in_dat[127:in_adr*8] in the hold buffer, and latch tgt, adr, sz and sext. Go to HOLD; wb_v is unaffected.
  - HOLD, accepting a beat: aligned = {in_dat, hold} with the second beat's bytes placed starting at byte n1. Use the latched attributes; in_tgt, in_adr, in_sz and in_sext of the second beat are ignored. Load the output register and return to IDLE.
- Extension:
  - Keep the low nbytes*8 bits of aligned.
  - If in_sext=1, bits above are copies of bit nbytes*8-1; otherwise they are 0.
  - n96 fills all 96 bits; no extension applies.
- Output register:
  - Loads on accept (non-split or second beat).
  - Clears wb_v on consume when no new load occurs that edge.
  - Consume and load in the same cycle: the new result replaces the old and wb_v stays 1. Full-throughput back-to-back is supported.
  - wb_tgt, wb_dat and wb_err hold stable while wb_v && !wb_rdy.
- flush_i=1: next state is IDLE, wb_v=0 and the hold buffer is discarded. A beat presented in the same cycle is dropped (in_rdy is still reported but the beat has no effect).
- wb_err=1 only with a result whose size code was 7; the data is still produced as a 12-byte load.
- No internal timeout: HOLD waits indefinitely for the second beat.

Test Plan:
- Non-split load: in_adr=4, in_sz=3, sext=1, in_dat[63:32]=32'h8000_0001, tgt=5 -> one cycle later wb_v=1, wb_tgt=5, wb_dat=96'hFFFF_FFFF_FFFF_FFFF_8000_0001; same with sext=0 -> 96'h0000_0000_0000_0000_8000_0001.
- Split load:
  - Stimulus: in_adr=14, in_sz=5, sext=0. Beat1 bytes 14,15=16'hBBAA. Beat2 bytes 0..5=48'h665544332211.
  - Required: no wb_v after beat1; one cycle after beat2, wb_dat=96'h0000_0000_6655_4433_2211_BBAA with tgt from beat1.
- Backpressure: hold wb_rdy=0 with wb_v=1 -> in_rdy=0 and wb_* stable for 5 cycles. Raise wb_rdy together with a new in_v -> the new result appears on the next cycle with wb_v never dropping.
- Flush in HOLD: accept a split first beat, assert flush_i -> state IDLE. A following non-split byte load (in_adr=0, data 8'h7F) -> wb_dat=96'h7F with no stale merge.
- Illegal size: in_sz=7, in_adr=0 -> wb_err=1, wb_dat=in_dat[95:0]. Next legal load -> wb_err=0.
- Reset mid-operation: assert rst_i while in HOLD with wb_v=1 -> next cycle wb_v=0, wb_dat=0, wb_tgt=0, in_rdy=0 during reset; the first beat after reset is treated as a fresh first beat.
